// File: rtl/legv8_pkg.sv
// Shared LEGv8 execute-unit definitions: opcode encodings, the zero-register index and FSM states.
package legv8_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_ORR  = 3'b011;
  localparam logic [2:0] OP_MOVB = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;

  localparam int XZR_INDEX = 31;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/legv8_seq_multiplier.sv
// Shift-add multiplier, one multiplier bit per cycle; o_done/o_product are valid on the final iteration.
module legv8_seq_multiplier #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_multiplicand,
  input  logic [DATA_WIDTH-1:0] i_multiplier,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_product
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  logic                  r_busy;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [DATA_WIDTH-1:0] r_acc;

  // Product after this cycle's iteration; exposed so the last step needs no extra cycle.
  assign o_product = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_done    = r_busy && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
    end else if (r_busy) begin
      if (r_cnt == LAST) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_start) begin
      r_mcand  <= i_multiplicand;
      r_mplier <= i_multiplier;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= o_product;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

endmodule

// File: rtl/legv8_execute_unit.sv
// LEGv8 execute stage: single-cycle ALU, optional sequential MUL, registered write-back outputs.
// Define LEGV8_EXEC_MUL_EN to build the multiplier; otherwise opcode 101 is illegal.
module legv8_execute_unit
  import legv8_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            opcode,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic [ADDR_WIDTH-1:0] dest_reg,
  output logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] write_reg_address,
  output logic                  reg_write,
  output logic                  zero_flag,
  output logic                  illegal_op
);

  localparam logic [ADDR_WIDTH-1:0] XZR_ADDR = ADDR_WIDTH'(XZR_INDEX);

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_accept;
  logic                  w_legal;
  logic                  w_is_mul;
  logic [DATA_WIDTH-1:0] w_alu_res;

  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic                  r_reg_write;
  logic                  r_zero;
  logic                  r_illegal;

  assign in_ready = (r_state == ST_IDLE);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_legal   = 1'b1;
    w_is_mul  = 1'b0;
    w_alu_res = '0;
    case (opcode)
      OP_ADD:  w_alu_res = operand_a + operand_b;
      OP_SUB:  w_alu_res = operand_a - operand_b;
      OP_AND:  w_alu_res = operand_a & operand_b;
      OP_ORR:  w_alu_res = operand_a | operand_b;
      OP_MOVB: w_alu_res = operand_b;
`ifdef LEGV8_EXEC_MUL_EN
      OP_MUL:  w_is_mul  = 1'b1;
`endif
      default: w_legal   = 1'b0;
    endcase
  end

`ifdef LEGV8_EXEC_MUL_EN
  logic                  w_mul_done;
  logic [DATA_WIDTH-1:0] w_mul_product;
  logic [ADDR_WIDTH-1:0] r_mul_dest;

  legv8_seq_multiplier #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mul (
    .clk            (clk),
    .reset          (reset),
    .i_start        (w_accept && w_is_mul),
    .i_multiplicand (operand_a),
    .i_multiplier   (operand_b),
    .o_done         (w_mul_done),
    .o_product      (w_mul_product)
  );

  always_ff @(posedge clk) begin
    if (w_accept && w_is_mul) r_mul_dest <= dest_reg;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_is_mul) w_state_next = ST_MUL;
      ST_MUL:  if (w_mul_done)           w_state_next = ST_IDLE;
      default:                           w_state_next = ST_IDLE;
    endcase
  end
`else
  always_comb begin
    w_state_next = ST_IDLE;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data      <= '0;
      r_waddr     <= '0;
      r_reg_write <= 1'b0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_reg_write <= 1'b0;
      r_illegal   <= 1'b0;
      if (w_accept && !w_is_mul) begin
        if (w_legal) begin
          r_data      <= w_alu_res;
          r_zero      <= (w_alu_res == '0);
          r_waddr     <= dest_reg;
          r_reg_write <= (dest_reg != XZR_ADDR);
        end else begin
          r_data    <= '0;
          r_zero    <= 1'b1;
          r_illegal <= 1'b1;
        end
      end
`ifdef LEGV8_EXEC_MUL_EN
      // Accept and completion never coincide: MUL state blocks new requests.
      if (w_mul_done) begin
        r_data      <= w_mul_product;
        r_zero      <= (w_mul_product == '0);
        r_waddr     <= r_mul_dest;
        r_reg_write <= (r_mul_dest != XZR_ADDR);
      end
`endif
    end
  end

  assign data              = r_data;
  assign write_reg_address = r_waddr;
  assign reg_write         = r_reg_write;
  assign zero_flag         = r_zero;
  assign illegal_op        = r_illegal;

endmodule

// File: tb/tb_legv8_execute_unit.sv
// Randomized bench for legv8_execute_unit against a cycle-level reference model, plus directed literal checks.
module tb_legv8_execute_unit;

  localparam int DW = 64;
  localparam int AW = 5;
`ifdef LEGV8_EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    opcode;
  logic [DW-1:0] operand_a;
  logic [DW-1:0] operand_b;
  logic [AW-1:0] dest_reg;
  logic [DW-1:0] data;
  logic [AW-1:0] write_reg_address;
  logic          reg_write;
  logic          zero_flag;
  logic          illegal_op;

  legv8_execute_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .opcode            (opcode),
    .operand_a         (operand_a),
    .operand_b         (operand_b),
    .dest_reg          (dest_reg),
    .data              (data),
    .write_reg_address (write_reg_address),
    .reg_write         (reg_write),
    .zero_flag         (zero_flag),
    .illegal_op        (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the outputs must read during the cycle after each edge.
  int            m_busy = 0;
  logic [DW-1:0] m_mul_res;
  logic [AW-1:0] m_mul_dest;
  logic [DW-1:0] exp_data  = '0;
  logic [AW-1:0] exp_waddr = '0;
  logic          exp_rw    = 1'b0;
  logic          exp_ill   = 1'b0;
  logic          exp_zero  = 1'b0;
  logic          exp_ready = 1'b1;

  function automatic logic [DW-1:0] alu_ref(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      default: return b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy    = 0;
      exp_data  = '0;
      exp_waddr = '0;
      exp_rw    = 1'b0;
      exp_ill   = 1'b0;
      exp_zero  = 1'b0;
    end else begin
      exp_rw  = 1'b0;
      exp_ill = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          exp_data  = m_mul_res;
          exp_zero  = (m_mul_res == 0);
          exp_waddr = m_mul_dest;
          exp_rw    = (m_mul_dest != 31);
        end
      end else if (in_valid) begin
        if (opcode == 3'd5 && MUL_EN) begin
          m_busy     = DW;
          m_mul_res  = operand_a * operand_b;
          m_mul_dest = dest_reg;
        end else if (opcode <= 3'd4) begin
          exp_data  = alu_ref(opcode, operand_a, operand_b);
          exp_zero  = (exp_data == 0);
          exp_waddr = dest_reg;
          exp_rw    = (dest_reg != 31);
        end else begin
          exp_ill  = 1'b1;
          exp_data = '0;
          exp_zero = 1'b1;
        end
      end
    end
    exp_ready = (m_busy == 0);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", {63'b0, in_ready}, {63'b0, exp_ready});
      check("reg_write", {63'b0, reg_write}, {63'b0, exp_rw});
      check("illegal_op", {63'b0, illegal_op}, {63'b0, exp_ill});
      check("data", data, exp_data);
      if (exp_rw) check("write_reg_address", {59'b0, write_reg_address}, {59'b0, exp_waddr});
      if (exp_rw || exp_ill) check("zero_flag", {63'b0, zero_flag}, {63'b0, exp_zero});
    end
  end

  task automatic issue(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [AW-1:0] d);
    @(negedge clk);
    in_valid  = 1'b1;
    opcode    = op;
    operand_a = a;
    operand_b = b;
    dest_reg  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic rw, input logic [DW-1:0] d, input logic z, input logic ill);
    check({tag, ".reg_write"}, {63'b0, reg_write}, {63'b0, rw});
    check({tag, ".data"}, data, d);
    check({tag, ".zero_flag"}, {63'b0, zero_flag}, {63'b0, z});
    check({tag, ".illegal_op"}, {63'b0, illegal_op}, {63'b0, ill});
  endtask

  initial begin
    int cnt;
    int pulses;
    reset     = 1'b1;
    in_valid  = 1'b0;
    opcode    = 3'd0;
    operand_a = '0;
    operand_b = '0;
    dest_reg  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, 64'd0, 1'b0, 1'b0);
    check("reset.waddr", {59'b0, write_reg_address}, 64'd0);
    check("reset.in_ready", {63'b0, in_ready}, 64'd1);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    issue(3'd0, 64'd5, 64'd7, 5'd3);
    check_outputs("add", 1'b1, 64'd12, 1'b0, 1'b0);
    check("add.waddr", {59'b0, write_reg_address}, 64'd3);

    issue(3'd1, 64'd0, 64'd1, 5'd2);
    check_outputs("sub_wrap", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    issue(3'd1, 64'd9, 64'd9, 5'd2);
    check_outputs("sub_zero", 1'b1, 64'd0, 1'b1, 1'b0);

    issue(3'd0, 64'd1, 64'd1, 5'd31);
    check("xzr.reg_write", {63'b0, reg_write}, 64'd0);
    check("xzr.data", data, 64'd2);

    issue(3'd7, 64'd3, 64'd4, 5'd1);
    check_outputs("illegal7", 1'b0, 64'd0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("illegal7.pulse_end", {63'b0, illegal_op}, 64'd0);

    if (MUL_EN) begin
      @(negedge clk);
      in_valid  = 1'b1;
      opcode    = 3'd5;
      operand_a = 64'h1_0000_0001;
      operand_b = 64'd3;
      dest_reg  = 5'd6;
      @(posedge clk);
      #1;
      opcode    = 3'd0;
      operand_a = 64'd2;
      operand_b = 64'd3;
      dest_reg  = 5'd4;
      cnt = 0;
      while (!in_ready && cnt < 200) begin
        cnt++;
        @(posedge clk);
        #1;
      end
      check("mul.busy_cycles", 64'(cnt), 64'd64);
      check_outputs("mul", 1'b1, 64'h3_0000_0003, 1'b0, 1'b0);
      check("mul.waddr", {59'b0, write_reg_address}, 64'd6);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_outputs("queued_add", 1'b1, 64'd5, 1'b0, 1'b0);
      check("queued_add.waddr", {59'b0, write_reg_address}, 64'd4);

      issue(3'd5, 64'd123, 64'd456, 5'd9);
      repeat (10) @(posedge clk);
    end else begin
      issue(3'd5, 64'd123, 64'd456, 5'd9);
      check_outputs("illegal5", 1'b0, 64'd0, 1'b1, 1'b1);
      issue(3'd0, 64'd8, 64'd8, 5'd9);
    end

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("mid_reset", 1'b0, 64'd0, 1'b0, 1'b0);
    check("mid_reset.waddr", {59'b0, write_reg_address}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset.in_ready", {63'b0, in_ready}, 64'd1);
    pulses = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (reg_write) pulses++;
    end
    check("post_reset.no_pulse", 64'(pulses), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset    = ($urandom_range(0, 199) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      opcode   = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       operand_a = '0;
        1:       operand_a = 64'($urandom_range(0, 15));
        default: operand_a = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 3))
        0:       operand_b = '0;
        1:       operand_b = operand_a;
        default: operand_b = {$urandom, $urandom};
      endcase
      dest_reg = 5'($urandom_range(0, 31));
    end
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (70) @(posedge clk);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
